// File: rtl/tt_trng_pkg.sv
// Shared definitions for the TRNG sequencer.
//   trng_state_e : sequencer states, IDLE=0 .. SHOW=5
//   DEF_*        : default parameter values
//   cnt_width    : width of the shared down-counter
//   run_width    : width of the health run-length counter
package tt_trng_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        SAMPLE  = 3'd3,
        PULSE   = 3'd4,
        SHOW    = 3'd5
    } trng_state_e;

    localparam int DEF_WARMUP_CYCLES  = 64;
    localparam int DEF_COLLECT_CYCLES = 8;
    localparam int DEF_PULSE_CYCLES   = 4;
    localparam int DEF_DISP_TOGGLE    = 1024;
    localparam int DEF_HEALTH_RUN     = 32;

    // The counter only ever holds (parameter - 1), so clog2 of the largest
    // parameter is enough; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int run_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tt_trng_ctrl_if.sv
// Signal bundle between the user inputs / TRNG datapath and the sequencer.
//   start_i, cont_i, rand_bit_i : towards the sequencer
//   startring_o, sample_o, pulse_o, disp_sel_o, busy_o, valid_o,
//   health_err_o                : from the sequencer
// master drives the inputs (top level / bench), slave is the sequencer.
interface tt_trng_ctrl_if;
    logic start_i;
    logic cont_i;
    logic rand_bit_i;
    logic startring_o;
    logic sample_o;
    logic pulse_o;
    logic disp_sel_o;
    logic busy_o;
    logic valid_o;
    logic health_err_o;

    modport master (
        output start_i, cont_i, rand_bit_i,
        input  startring_o, sample_o, pulse_o, disp_sel_o, busy_o, valid_o, health_err_o
    );

    modport slave (
        input  start_i, cont_i, rand_bit_i,
        output startring_o, sample_o, pulse_o, disp_sel_o, busy_o, valid_o, health_err_o
    );
endinterface

// File: rtl/tt_trng_health.sv
// Repetition-count test on the raw ring bitstream.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : test active (WARMUP / COLLECT); run restarts when low
//   clr        : clears the sticky error flag
//   bit_i      : raw entropy bit
//   hit        : this cycle's bit completes a run of HEALTH_RUN identical bits
//   err        : sticky error, including the current hit
module tt_trng_health
    import tt_trng_pkg::*;
#(
    parameter int HEALTH_RUN = DEF_HEALTH_RUN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic bit_i,
    output logic hit,
    output logic err
);
    localparam int RW = run_width(HEALTH_RUN);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_now;
    logic          last_q;
    logic          err_q;

    // Length of the run ending with the current bit.
    always_comb begin
        run_now = RW'(1);
        if (run_q != '0 && bit_i == last_q) run_now = run_q + RW'(1);
    end

    assign hit = en && (run_now == RW'(HEALTH_RUN));
    assign err = err_q | hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            run_q <= en ? run_now : '0;
            if (en) last_q <= bit_i;
            if (clr) err_q <= 1'b0;
            if (hit) err_q <= 1'b1;
        end
    end
endmodule

// File: rtl/tt_trng_ctrl.sv
// TRNG sequencer: ring warm-up, bit collection, key sample strobe, arbiter
// challenge pulse and A/B display alternation.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : tt_trng_ctrl_if.slave (start/cont/rand_bit in, strobes out)
// Build option: define TT_TRNG_CTRL_HEALTH_EN to enable the stuck-source
// monitor; otherwise rand_bit_i is ignored and health_err_o is 0.
//
// state   | meaning
// IDLE    | everything off, wait for start
// WARMUP  | rings running, WARMUP_CYCLES
// COLLECT | rings running, bitstream shifting, COLLECT_CYCLES
// SAMPLE  | one-cycle key sample strobe
// PULSE   | rings off, arbiter pulse for PULSE_CYCLES
// SHOW    | key valid, display alternates every DISP_TOGGLE cycles
module tt_trng_ctrl
    import tt_trng_pkg::*;
#(
    parameter int WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
    parameter int COLLECT_CYCLES = DEF_COLLECT_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int DISP_TOGGLE    = DEF_DISP_TOGGLE,
    parameter int HEALTH_RUN     = DEF_HEALTH_RUN
) (
    input  logic          clk,
    input  logic          rst_n,
    tt_trng_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WARMUP_CYCLES, COLLECT_CYCLES, PULSE_CYCLES, DISP_TOGGLE);

    trng_state_e   state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          disp_q, disp_n;
    logic          start_q, start_prev, start_evt;
    logic          health_hit, health_err;
    logic          startring, sample, pulse, disp_sel, busy, valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_q    <= bus.start_i;
            start_prev <= start_q;
        end
    end

    assign start_evt = start_q & ~start_prev;

`ifdef TT_TRNG_CTRL_HEALTH_EN
    logic health_en;
    assign health_en = (state_q == WARMUP) || (state_q == COLLECT);

    tt_trng_health #(.HEALTH_RUN(HEALTH_RUN)) u_health (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (health_en),
        .clr   (start_evt),
        .bit_i (bus.rand_bit_i),
        .hit   (health_hit),
        .err   (health_err)
    );
`else
    localparam int unused_health_run = HEALTH_RUN;
    logic unused_rand_bit;
    assign unused_rand_bit = bus.rand_bit_i;
    assign health_hit      = 1'b0;
    assign health_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            disp_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            disp_q  <= disp_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        disp_n    = disp_q;
        startring = 1'b0;
        sample    = 1'b0;
        pulse     = 1'b0;
        disp_sel  = 1'b0;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_n = WARMUP;
                    cnt_n   = CW'(WARMUP_CYCLES - 1);
                end
            end
            WARMUP: begin
                startring = 1'b1;
                busy      = 1'b1;
                if (health_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == '0) begin
                    state_n = COLLECT;
                    cnt_n   = CW'(COLLECT_CYCLES - 1);
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            COLLECT: begin
                startring = 1'b1;
                busy      = 1'b1;
                if (health_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == '0) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            SAMPLE: begin
                startring = 1'b1;
                sample    = 1'b1;
                busy      = 1'b1;
                state_n   = PULSE;
                cnt_n     = CW'(PULSE_CYCLES - 1);
            end
            PULSE: begin
                pulse = 1'b1;
                busy  = 1'b1;
                if (cnt_q == '0) begin
                    state_n = SHOW;
                    cnt_n   = CW'(DISP_TOGGLE - 1);
                    disp_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            SHOW: begin
                valid    = 1'b1;
                disp_sel = disp_q;
                if (start_evt) begin
                    state_n = WARMUP;
                    cnt_n   = CW'(WARMUP_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    // disp_q low here means the B half just ended: a full
                    // A+B period is complete, the point where continuous
                    // mode restarts.
                    cnt_n  = CW'(DISP_TOGGLE - 1);
                    disp_n = ~disp_q;
                    if (!disp_q && bus.cont_i) begin
                        state_n = WARMUP;
                        cnt_n   = CW'(WARMUP_CYCLES - 1);
                    end
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.startring_o  = startring;
    assign bus.sample_o     = sample;
    assign bus.pulse_o      = pulse;
    assign bus.disp_sel_o   = disp_sel;
    assign bus.busy_o       = busy;
    assign bus.valid_o      = valid;
    assign bus.health_err_o = health_err;
endmodule

// File: tb/tb_tt_trng_ctrl.sv
module tb_tt_trng_ctrl;
    localparam int W = 64, C = 8, P = 4, D = 4, HR = 8;
    localparam int SHOW_T = W + C + 1 + P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    tt_trng_ctrl_if bus();

    tt_trng_ctrl #(
        .WARMUP_CYCLES(W), .COLLECT_CYCLES(C), .PULSE_CYCLES(P),
        .DISP_TOGGLE(D), .HEALTH_RUN(HR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a capture is a timeline indexed by cycles since WARMUP entry.
    bit   m_run;
    int   m_t;
    logic m_sq, m_sp, m_err, m_last;
    int   m_hrun;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_sq = 0; m_sp = 0; m_err = 0; m_hrun = 0; m_last = 0;
    endtask

`ifdef TT_TRNG_CTRL_HEALTH_EN
    function automatic int next_run();
        return (m_hrun > 0 && bus.rand_bit_i == m_last) ? m_hrun + 1 : 1;
    endfunction
`endif

    task automatic model_edge();
        logic evt;
        logic hit;
        evt = m_sq & ~m_sp;
        m_sp = m_sq;
        m_sq = bus.start_i;
        hit = 1'b0;
        if (evt) m_err = 1'b0;
`ifdef TT_TRNG_CTRL_HEALTH_EN
        if (m_run && m_t < W + C) begin
            int nr;
            nr = next_run();
            m_last = bus.rand_bit_i;
            m_hrun = nr;
            if (nr == HR) begin hit = 1'b1; m_err = 1'b1; end
        end else m_hrun = 0;
`endif
        if (!m_run) begin
            if (evt) begin m_run = 1; m_t = 0; end
        end else if (hit) begin
            m_run = 0;
        end else if (m_t < SHOW_T) begin
            m_t++;
        end else if (evt || (bus.cont_i && ((m_t - SHOW_T) % (2 * D)) == 2 * D - 1)) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    // {startring, sample, pulse, disp_sel, busy, valid, health_err}
    function automatic logic [6:0] expect_out();
        logic sr, sa, pu, ds, bu, va, er;
        sr = 0; sa = 0; pu = 0; ds = 0; bu = 0; va = 0;
        if (m_run) begin
            sr = (m_t <= W + C);
            sa = (m_t == W + C);
            pu = (m_t > W + C) && (m_t < SHOW_T);
            va = (m_t >= SHOW_T);
            bu = !va;
            if (va) ds = (((m_t - SHOW_T) / D) % 2) == 0;
        end
        er = m_err;
`ifdef TT_TRNG_CTRL_HEALTH_EN
        if (m_run && m_t < W + C && next_run() == HR) er = 1'b1;
`endif
        return {sr, sa, pu, ds, bu, va, er};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.startring_o, bus.sample_o, bus.pulse_o, bus.disp_sel_o,
                bus.busy_o, bus.valid_o, bus.health_err_o};
    endfunction

    // One clock: model follows the edge, then inputs for the next cycle are applied.
    task automatic cyc(input logic s, input logic c, input logic r);
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        bus.start_i = s; bus.cont_i = c; bus.rand_bit_i = r;
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] o, e;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== 7'b0) $display("FAIL reset_outputs: got %b want 0000000", obs()); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL reset_idle c%0d: got %b want %b", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_capture();
        int sr_cnt = 0, smp_w = 0, pul_w = 0, entry = -1, smp_i = -1, pul_i = -1, show_i = 0;
        logic seen_sample = 0;
        logic [8:0] dseq = '0;
        logic [6:0] o, e;
        for (int i = 0; i < SHOW_T + 20; i++) begin
            cyc(i < 3, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL capture c%0d: got %b want %b", i, o, e); else n_pass++;
            if (bus.startring_o && entry < 0) entry = i;
            if (bus.startring_o && !bus.sample_o && !seen_sample) sr_cnt++;
            if (bus.sample_o) begin smp_w++; seen_sample = 1; if (smp_i < 0) smp_i = i; end
            if (bus.pulse_o) begin pul_w++; if (pul_i < 0) pul_i = i; end
            if (bus.valid_o && show_i < 9) begin dseq[8 - show_i] = bus.disp_sel_o; show_i++; end
        end
        n_chk++; if (entry !== 2) $display("FAIL start_latency: got %0d want 2", entry); else n_pass++;
        n_chk++; if (sr_cnt !== W + C) $display("FAIL ring_before_sample: got %0d want %0d", sr_cnt, W + C); else n_pass++;
        n_chk++; if (smp_w !== 1) $display("FAIL sample_width: got %0d want 1", smp_w); else n_pass++;
        n_chk++; if (pul_w !== P) $display("FAIL pulse_width: got %0d want %0d", pul_w, P); else n_pass++;
        n_chk++; if (pul_i !== smp_i + 1) $display("FAIL pulse_after_sample: got %0d want %0d", pul_i, smp_i + 1); else n_pass++;
        n_chk++; if (dseq !== 9'b111100001) $display("FAIL disp_seq: got %b want 111100001", dseq); else n_pass++;
        n_chk++; if (bus.valid_o !== 1'b1) $display("FAIL valid_after: got %b want 1", bus.valid_o); else n_pass++;
    endtask

    task automatic test_cont();
        int show_len = 0, reent = 0, drop_at;
        logic prev_v, first = 1, still_show = 1;
        logic [6:0] o, e;
        prev_v = bus.valid_o;
        for (int i = 0; i < 4 * (SHOW_T + 2 * D); i++) begin
            cyc(1'b0, 1'b1, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL cont c%0d: got %b want %b", i, o, e); else n_pass++;
            if (bus.valid_o) show_len++;
            else if (prev_v) begin
                if (!first) begin
                    n_chk++;
                    if (show_len !== 2 * D) $display("FAIL cont_show_len: got %0d want %0d", show_len, 2 * D); else n_pass++;
                    reent++;
                end
                first = 0;
                show_len = 0;
            end
            prev_v = bus.valid_o;
        end
        n_chk++; if (reent < 2) $display("FAIL cont_reentries: got %0d want >=2", reent); else n_pass++;
        // Drop cont partway through a SHOW period; the FSM must stay in SHOW.
        for (int i = 0; i < 200 && !bus.valid_o; i++) cyc(1'b0, 1'b1, 1'(i % 2));
        drop_at = $urandom_range(0, 2 * D - 2);
        for (int i = 0; i < drop_at; i++) cyc(1'b0, 1'b1, 1'(i % 2));
        for (int i = 0; i < 6 * D; i++) begin
            cyc(1'b0, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL cont_drop c%0d: got %b want %b", i, o, e); else n_pass++;
            if (!bus.valid_o) still_show = 0;
        end
        n_chk++; if (still_show !== 1'b1) $display("FAIL cont_drop_stays_show: got %b want 1", still_show); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int entry = -1, smp_i = -1;
        logic s;
        logic [6:0] o, e;
        for (int i = 0; i < SHOW_T + 30; i++) begin
            s = (i < 2) || (entry >= 0 && i >= entry + 10 && i < entry + 12);
            cyc(s, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL start_ignored c%0d: got %b want %b", i, o, e); else n_pass++;
            if (bus.startring_o && entry < 0) entry = i;
            if (bus.sample_o && smp_i < 0) smp_i = i;
        end
        n_chk++;
        if (smp_i - entry !== W + C) $display("FAIL ignored_start_timing: got %0d want %0d", smp_i - entry, W + C); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic found = 0;
        logic [6:0] o, e;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(i < 2, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL to_pulse c%0d: got %b want %b", i, o, e); else n_pass++;
            if (bus.pulse_o) found = 1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL pulse_timeout: got %b want 1", found); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (obs() !== 7'b0) $display("FAIL async_reset: got %b want 0000000", obs()); else n_pass++;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e || bus.busy_o !== 1'b0) $display("FAIL post_reset_idle c%0d: got %b want %b", i, o, e); else n_pass++;
        end
    endtask

`ifdef TT_TRNG_CTRL_HEALTH_EN
    task automatic test_health();
        int wcnt = 0, err_at = -1, err_i = -1;
        logic busy_after = 1'b1;
        logic [6:0] o, e;
        for (int i = 0; i < 40; i++) begin
            cyc(i < 2, 1'b0, 1'b0);
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL health c%0d: got %b want %b", i, o, e); else n_pass++;
            if (bus.startring_o && err_at < 0) wcnt++;
            if (bus.health_err_o && err_at < 0) begin err_at = wcnt; err_i = i; end
            if (err_i >= 0 && i == err_i + 1) busy_after = bus.busy_o;
        end
        n_chk++; if (err_at !== HR) $display("FAIL health_trip_cycle: got %0d want %0d", err_at, HR); else n_pass++;
        n_chk++; if (busy_after !== 1'b0) $display("FAIL health_to_idle: got %b want 0", busy_after); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            cyc(i < 2, 1'b0, 1'(i % 2));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL health_clear c%0d: got %b want %b", i, o, e); else n_pass++;
        end
        n_chk++; if (bus.health_err_o !== 1'b0) $display("FAIL health_sticky_clear: got %b want 0", bus.health_err_o); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic s = 0, c = 0;
        logic [6:0] o, e;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) s = ~s;
            if ($urandom_range(0, 99) == 0) c = ~c;
            cyc(s, c, 1'($urandom_range(0, 1)));
            o = obs(); e = expect_out();
            n_chk++;
            if (o !== e) $display("FAIL random c%0d: got %b want %b", i, o, e); else n_pass++;
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.cont_i = 1'b0;
        bus.rand_bit_i = 1'b0;
        model_reset();
        test_reset();
        test_capture();
        test_cont();
        test_start_ignored();
        test_reset_mid();
`ifdef TT_TRNG_CTRL_HEALTH_EN
        test_health();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
